xpb_reduce_seq: RTL and testbench

//  Sequences one shared bank of registered xpb lookup ROMs (5-bit index -> WORD_W-bit precomputed multiple).

---
 rtl/xpb_ctrl_pkg.sv | 14 +
 rtl/xpb_seg_pick.sv | 28 ++
 rtl/xpb_reduce_seq.sv | 166 ++++++++++++++++
 tb/tb_xpb_reduce_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_ctrl_pkg.sv
// Shared state encoding, widths and carry sizing for the xpb reduction sequencer.
package xpb_ctrl_pkg;

  localparam int SEG_W = 5;
  localparam int XPB_W = 1024;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Headroom needed to sum a base plus n full-width words without wrap.
  function automatic int carry_bits(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/xpb_seg_pick.sv
// Finds the lowest set mask bit above ptr (or at ptr when incl is set).
// last=1 means no such bit exists; next_ptr is then 0.
module xpb_seg_pick
  import xpb_ctrl_pkg::*;
#(
  parameter int NUM_SEG = 8,
  parameter int PW      = 3
) (
  input  logic [NUM_SEG-1:0] mask,
  input  logic [PW-1:0]      ptr,
  input  logic               incl,
  output logic [PW-1:0]      next_ptr,
  output logic               last
);

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    next_ptr = '0;
    last     = 1'b1;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(ptr)) || (incl && (i == int'(ptr))))) begin
        next_ptr = PW'(i);
        last     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xpb_reduce_seq.sv
// Issues one xpb ROM lookup per cycle per segment and accumulates base + sum of returned words.
// Optional XPB_SKIP_ZERO_EN skips lookups for zero segments.
module xpb_reduce_seq #(
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = xpb_ctrl_pkg::SEG_W,
  parameter int WORD_W  = xpb_ctrl_pkg::XPB_W
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_SEG*SEG_W-1:0]                      in_segs,
  input  logic [WORD_W-1:0]                             in_base,
  output logic [$clog2(NUM_SEG)-1:0]                    xpb_sel,
  output logic [SEG_W-1:0]                              xpb_idx,
  input  logic [WORD_W-1:0]                             xpb_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [WORD_W+xpb_ctrl_pkg::carry_bits(NUM_SEG)-1:0] out_sum
);

  import xpb_ctrl_pkg::*;

  localparam int PW = $clog2(NUM_SEG);
  localparam int CW = carry_bits(NUM_SEG);
  localparam int SW = WORD_W + CW;

  state_t                   state_q, state_d;
  logic [NUM_SEG*SEG_W-1:0] segs_q, segs_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     pending_q, pending_d;
  logic [SW-1:0]            acc_q, acc_d;

  logic                     accept;
  logic [SEG_W-1:0]         cur_seg;
  logic [PW-1:0]            first_ptr;
  logic [PW-1:0]            nxt_ptr;
  logic                     mask_empty;
  logic                     issue_last;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE) && !rst;
  assign out_sum   = acc_q;

`ifdef XPB_SKIP_ZERO_EN
  logic [NUM_SEG-1:0] mask_q, mask_d;
  logic [NUM_SEG-1:0] in_mask;
  logic               first_none;
  logic               nxt_none;

  always_comb begin
    in_mask = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      in_mask[i] = |in_segs[i*SEG_W +: SEG_W];
    end
  end

  assign mask_d = accept ? in_mask : mask_q;

  xpb_seg_pick #(.NUM_SEG(NUM_SEG), .PW(PW)) u_pick_first (
    .mask     (in_mask),
    .ptr      ('0),
    .incl     (1'b1),
    .next_ptr (first_ptr),
    .last     (first_none)
  );

  xpb_seg_pick #(.NUM_SEG(NUM_SEG), .PW(PW)) u_pick_next (
    .mask     (mask_q),
    .ptr      (ptr_q),
    .incl     (1'b0),
    .next_ptr (nxt_ptr),
    .last     (nxt_none)
  );

  assign mask_empty = first_none;
  assign issue_last = nxt_none;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign first_ptr  = '0;
  assign mask_empty = 1'b0;
  assign nxt_ptr    = ptr_q + PW'(1);
  assign issue_last = (ptr_q == PW'(NUM_SEG - 1));
`endif

  always_comb begin
    cur_seg = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (ptr_q == PW'(i)) begin
        cur_seg = segs_q[i*SEG_W +: SEG_W];
      end
    end
  end

  // xpb_data answers the lookup issued one cycle earlier; pending_q marks that.
  always_comb begin
    state_d   = state_q;
    segs_d    = segs_q;
    ptr_d     = ptr_q;
    pending_d = 1'b0;
    acc_d     = acc_q;
    xpb_sel   = '0;
    xpb_idx   = '0;

    if (pending_q) begin
      acc_d = acc_q + SW'(xpb_data);
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          segs_d  = in_segs;
          acc_d   = SW'(in_base);
          ptr_d   = first_ptr;
          state_d = mask_empty ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        xpb_sel   = ptr_q;
        xpb_idx   = cur_seg;
        pending_d = 1'b1;
        if (issue_last) begin
          state_d = DRAIN;
        end else begin
          ptr_d = nxt_ptr;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      segs_q    <= '0;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      segs_q    <= segs_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Self-checking bench for xpb_reduce_seq with a registered xpb ROM model.
module tb_xpb_reduce_seq;

  localparam int N  = 8;
  localparam int S  = 5;
  localparam int W  = 1024;
  localparam int CW = 4;
  localparam int SW = W + CW;
`ifdef XPB_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*S-1:0] in_segs = '0;
  logic [W-1:0]  in_base = '0;
  logic [2:0]    xpb_sel;
  logic [S-1:0]  xpb_idx;
  logic [W-1:0]  xpb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_sum;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  xpb_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_segs   (in_segs),
    .in_base   (in_base),
    .xpb_sel   (xpb_sel),
    .xpb_idx   (xpb_idx),
    .xpb_data  (xpb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    xpb_data  <= (xpb_idx == 0) ? '0 : W'(16 * int'(xpb_sel) + int'(xpb_idx));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] model_sum(input logic [N*S-1:0] segs, input logic [W-1:0] base);
    logic [SW-1:0] s;
    int v;
    s = SW'(base);
    for (int i = 0; i < N; i++) begin
      v = int'(segs[i*S +: S]);
      if (v != 0) s = s + SW'(16 * i + v);
    end
    return s;
  endfunction

  function automatic logic [W-1:0] rand_base();
    logic [W-1:0] b;
    for (int k = 0; k < W / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [N*S-1:0] rand_segs();
    logic [N*S-1:0] s;
    for (int i = 0; i < N; i++) s[i*S +: S] = ($urandom_range(0, 3) == 0) ? 5'd0 : S'($urandom);
    return s;
  endfunction

  // One full transaction: accept, check issue order, latency, sum, optional stall, handoff.
  task automatic do_op(input logic [N*S-1:0] segs, input logic [W-1:0] base, input int stall,
                       input bit hold, output int acc_cyc, output int lat, output logic [SW-1:0] got);
    logic [SW-1:0] exp_sum;
    int visit[$];
    int c;
    bit seen;
    exp_sum = model_sum(segs, base);
    for (int i = 0; i < N; i++) if (!SKIP || segs[i*S +: S] != 0) visit.push_back(i);
    lat = (visit.size() == 0) ? 1 : visit.size() + 2;
    c = 0;
    while (!in_ready && c < 20) begin tick(); c++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_wait: in_ready=%b required 1", in_ready); end
    in_valid = 1'b1; in_segs = segs; in_base = base; acc_cyc = cycle_cnt;
    c = 0; seen = 0;
    while (!seen && c < 40) begin
      tick(); c++;
      if (c == 1) begin
        if (hold) begin in_segs = {$urandom, $urandom}; in_base = ~base; end
        else in_valid = 1'b0;
      end
      if (c <= visit.size()) begin
        checks++;
        if (xpb_sel !== 3'(visit[c-1]) || xpb_idx !== segs[visit[c-1]*S +: S]) begin
          errors++;
          $display("FAIL issue c=%0d: sel=%0d idx=%0d required sel=%0d idx=%0d", c, xpb_sel, xpb_idx,
                   visit[c-1], segs[visit[c-1]*S +: S]);
        end
      end
      if (out_valid === 1'b1) seen = 1;
    end
    in_valid = 1'b0;
    got = out_sum;
    checks++;
    if (!seen || c != lat) begin errors++; $display("FAIL latency: out_valid at cycle %0d (seen=%0b) required %0d", c, seen, lat); end
    checks++;
    if (out_sum !== exp_sum) begin errors++; $display("FAIL sum: got %h required %h", out_sum, exp_sum); end
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++;
      if (out_sum !== exp_sum || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall %0d: out_valid=%b in_ready=%b sum=%h required 1 0 %h", s, out_valid, in_ready, out_sum, exp_sum);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL handoff: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_hold: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || xpb_sel !== 3'd0 || xpb_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h sel=%0d idx=%0d required 1 0 0 0 0",
               in_ready, out_valid, out_sum, xpb_sel, xpb_idx);
    end
  endtask

  task automatic test_all_ones();
    int a, l;
    logic [SW-1:0] g;
    do_op({N{5'd1}}, '0, 0, 0, a, l, g);
    checks++;
    if (g !== SW'(456)) begin errors++; $display("FAIL all_ones: got %0d required 456", g); end
  endtask

  task automatic test_carry();
    int a, l;
    logic [SW-1:0] g;
    logic [N*S-1:0] s;
    s = '0; s[4:0] = 5'd3;
    do_op(s, {W{1'b1}}, 0, 0, a, l, g);
    checks++;
    if (g[SW-1:W] !== 4'd1 || g[W-1:0] !== W'(2)) begin
      errors++; $display("FAIL carry: top=%0d low=%0d required 1 2", g[SW-1:W], g[W-1:0]);
    end
  endtask

  task automatic test_skip_zero();
    int a, l;
    logic [SW-1:0] g;
    logic [N*S-1:0] s;
    logic [W-1:0] b;
    b = rand_base();
    s = '0; s[5*S +: S] = 5'd7;
    do_op(s, b, 0, 0, a, l, g);
    checks++;
    if (g !== SW'(b) + SW'(87)) begin errors++; $display("FAIL seg5_only: got %h required base+87", g); end
    do_op('0, b, 0, 0, a, l, g);
    checks++;
    if (g !== SW'(b)) begin errors++; $display("FAIL all_zero: got %h required %h", g, SW'(b)); end
  endtask

  task automatic test_stall_back_to_back();
    int a1, a2, l1, l2;
    logic [SW-1:0] g;
    do_op(rand_segs(), rand_base(), 5, 0, a1, l1, g);
    do_op(rand_segs(), rand_base(), 0, 0, a1, l1, g);
    do_op(rand_segs(), rand_base(), 0, 0, a2, l2, g);
    checks++;
    if (a2 - a1 != l1 + 1) begin errors++; $display("FAIL period: %0d cycles required %0d", a2 - a1, l1 + 1); end
  endtask

  task automatic test_abort();
    int a, l;
    logic [SW-1:0] g;
    in_valid = 1'b1; in_segs = {N{5'd9}}; in_base = rand_base();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_rst: in_ready=%b required 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0) begin
      errors++; $display("FAIL abort: in_ready=%b out_valid=%b sum=%h required 1 0 0", in_ready, out_valid, out_sum);
    end
    do_op({N{5'd2}}, '0, 0, 0, a, l, g);
    checks++;
    if (g !== SW'(464)) begin errors++; $display("FAIL after_abort: got %0d required 464", g); end
  endtask

  task automatic test_hold_valid();
    int a, l;
    logic [SW-1:0] g;
    do_op(rand_segs(), rand_base(), 2, 1, a, l, g);
    do_op({N{5'd31}}, rand_base(), 0, 1, a, l, g);
  endtask

  task automatic test_random();
    int a, l;
    logic [SW-1:0] g;
    for (int k = 0; k < 8; k++) do_op(rand_segs(), rand_base(), $urandom_range(0, 3), 0, a, l, g);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_carry();
    test_skip_zero();
    test_stall_back_to_back();
    test_abort();
    test_hold_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
